servo_frame_ctrl: RTL
=====================

Name: servo_frame_ctrl

Overview:
- Timing and update controller for the two servo PWM comparator channels (left/right).
- Generates the shared 1 µs-resolution frame counter (0..19999, 20 ms, 50 Hz) and per-channel compare values.
- Accepts position samples from the SPI front-end via a valid/ready handshake and commits them only at frame boundaries, so pulses are never glitched.
- Contains a link watchdog that parks both servos at centre when samples stop arriving.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1_000_000, counter tick rate; DIV = CLK_HZ/TICK_HZ = 100.
- FRAME_TICKS, 20000, ticks per PWM frame.
- POS_MAX, 1000, maximum raw sample value; larger values are clamped.
- OFFSET, 1000, added to every committed position (1000..2000 µs pulse).
- TIMEOUT_FRAMES, 25, frames without any accepted sample before HOLD.
- SLEW_STEP, 20, maximum change per frame when slew limiting is enabled.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sample_valid  in  1  new sample present.
- sample_ready  out  1  controller can accept a sample.
- sample_ch  in  1  target channel: 0 = left, 1 = right.
- sample_x  in  10  raw position, 0..1023.
- cntr_val  out  15  frame counter, 0..FRAME_TICKS-1, µs units.
- x_val_left  out  11  left compare value.
- x_val_right  out  11  right compare value.
- frame_start  out  1  one-cycle pulse; cntr_val has just wrapped to 0.
- link_ok  out  1  high in RUN state.

Behaviour:
- **Reset (rst = 0, asynchronous).** Prescaler = 0, cntr_val = 0, x_val_left/right = 0 (no pulses), shadows = 500, fresh = 0, frame_start = 0, link_ok = 0, state = OFF. Reset asserted mid-frame takes effect immediately. After release, counting restarts from 0.
- **Prescaler.** Counts 0..DIV-1; tick = (prescaler == DIV-1).
- **Frame counter.** On tick, cntr_val increments; at FRAME_TICKS-1 it wraps to 0.
- **Commit cycle.** The clk edge on which the wrap occurs is the commit cycle. frame_start is registered high for exactly the following cycle, aligned with cntr_val == 0.
- **Handshake.**
  - A sample is accepted when sample_valid && sample_ready.
  - sample_ready = 1 except in the cycle whose tick causes a wrap (commit cycle), where it is 0.
  - A sample held valid through that cycle is accepted on the next cycle and applies to the following frame.
- **Accept.** shadow[sample_ch] <= min(sample_x, POS_MAX); fresh <= 1. Back-to-back accepts on consecutive cycles are legal; the last write per channel wins.
- **States** (evaluated at commit):
  - OFF: if fresh, go to RUN and commit shadows; otherwise outputs stay 0.
  - RUN: commit x_val = OFFSET + shadow per channel. If fresh, clear the frame-miss counter; otherwise increment it. When the counter reaches TIMEOUT_FRAMES, go to HOLD.
  - HOLD: x_val_left = x_val_right = OFFSET + 500 = 1500. If fresh, go to RUN and commit shadows.
- **Commit side effects.** fresh is cleared at every commit. The miss counter saturates and is cleared on entry to RUN.
- **Width rules.** Commit values are always in 1000..2000 and fit 11 bits. cntr_val never exceeds 19999.

Optional Feature:
- Macro: SERVO_SLEW_LIMIT_EN.
- Defined: in RUN → RUN commits, each x_val moves toward OFFSET + shadow by at most SLEW_STEP per frame, reaching the target exactly (no overshoot). OFF → RUN and HOLD → RUN commits jump directly to target.
- Undefined: direct commit, no step limiting.

Decomposition:
- Package servo_pkg:
  - Constants: FRAME_TICKS, OFFSET, POS_MAX, CENTER = 500.
  - Widths: CNTR_W = 15, XVAL_W = 11, POS_W = 10.
  - Enum: ctrl_state_t {OFF, RUN, HOLD}.
- Sub-module servo_tick_gen: prescaler plus frame counter. Outputs cntr_val, tick and wrap strobe. Reused by any future servo channels.

Test Plan:
- Reset then no samples for 3 frames → x_val_left/right = 0, link_ok = 0, frame_start pulses every 2,000,000 clk with cntr_val = 0.
- Left 300, right 700 accepted mid-frame → at next frame_start x_val_left = 1300, x_val_right = 1700, link_ok = 1; values unchanged during the accepting frame.
- sample_x = 1023 on left → committed x_val_left = 2000.
- sample_valid held high across the commit cycle → sample_ready low for exactly that cycle; sample applied one frame later.
- After RUN, stop samples → after 25 frames x_val = 1500 both, link_ok = 0; one new sample of 0 → next commit x_val_left = 1000, link_ok = 1.
- With SERVO_SLEW_LIMIT_EN: x_val_left at 1000, sample 100 → commits of 1020, 1040, 1060, 1080, 1100, then stays 1100.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, widths, controller state type and slew helper for the servo timing blocks.
package servo_pkg;

    localparam int CNTR_W      = 15;
    localparam int XVAL_W      = 11;
    localparam int POS_W       = 10;

    localparam int FRAME_TICKS = 20000;
    localparam int OFFSET      = 1000;
    localparam int POS_MAX     = 1000;
    localparam int CENTER      = 500;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctrl_state_t;

    // Move cur toward target by at most step, landing exactly on target.
    function automatic logic [XVAL_W-1:0] slew_toward(
        input logic [XVAL_W-1:0] cur,
        input logic [XVAL_W-1:0] target,
        input logic [XVAL_W-1:0] step
    );
        if (target > cur) begin
            return ((target - cur) > step) ? cur + step : target;
        end else begin
            return ((cur - target) > step) ? cur - step : target;
        end
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler plus frame counter: produces the 1-tick counter value, the tick strobe and the wrap strobe.
module servo_tick_gen
    import servo_pkg::*;
#(
    parameter int DIV         = 100,
    parameter int FRAME_TICKS = 20000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [CNTR_W-1:0] cntr_val,
    output logic              tick,
    output logic              wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;

    assign tick = (presc == PW'(DIV - 1));
    assign wrap = tick && (cntr_val == CNTR_W'(FRAME_TICKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            cntr_val <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (wrap) begin
                cntr_val <= '0;
            end else if (tick) begin
                cntr_val <= cntr_val + 1'b1;
            end
        end
    end

endmodule

// File: rtl/servo_frame_ctrl.sv
// Frame timing, sample capture and frame-boundary commit for the left/right servo comparators.
// Optional step limiting of RUN->RUN commits is built when SERVO_SLEW_LIMIT_EN is defined.
module servo_frame_ctrl #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int TICK_HZ        = 1_000_000,
    parameter int FRAME_TICKS    = 20000,
    parameter int POS_MAX        = 1000,
    parameter int OFFSET         = 1000,
    parameter int TIMEOUT_FRAMES = 25,
    parameter int SLEW_STEP      = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic                         sample_ch,
    input  logic [servo_pkg::POS_W-1:0]  sample_x,
    output logic [servo_pkg::CNTR_W-1:0] cntr_val,
    output logic [servo_pkg::XVAL_W-1:0] x_val_left,
    output logic [servo_pkg::XVAL_W-1:0] x_val_right,
    output logic                         frame_start,
    output logic                         link_ok,
    output servo_pkg::ctrl_state_t       ctrl_state
);

    import servo_pkg::*;

    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);

    logic              tick;
    logic              wrap;
    logic              commit;
    logic              accept;
    logic              fresh;
    logic [MISS_W-1:0] miss_cnt;
    logic [POS_W-1:0]  shadow_left;
    logic [POS_W-1:0]  shadow_right;
    logic [POS_W-1:0]  sample_clamped;
    logic [XVAL_W-1:0] target_left;
    logic [XVAL_W-1:0] target_right;
    logic [XVAL_W-1:0] run_left;
    logic [XVAL_W-1:0] run_right;
    logic [XVAL_W-1:0] center_val;

    servo_tick_gen #(
        .DIV         (DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .cntr_val (cntr_val),
        .tick     (tick),
        .wrap     (wrap)
    );

    // Valid/ready: a sample transfers on any clk edge where sample_valid && sample_ready;
    // ready drops only in the commit cycle so shadows are frozen while they are committed.
    assign commit       = tick && wrap;
    assign sample_ready = !commit;
    assign accept       = sample_valid && sample_ready;

    assign sample_clamped = (sample_x > POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : sample_x;
    assign target_left    = XVAL_W'(OFFSET) + XVAL_W'(shadow_left);
    assign target_right   = XVAL_W'(OFFSET) + XVAL_W'(shadow_right);
    assign center_val     = XVAL_W'(OFFSET + CENTER);

`ifdef SERVO_SLEW_LIMIT_EN
    assign run_left  = slew_toward(x_val_left,  target_left,  XVAL_W'(SLEW_STEP));
    assign run_right = slew_toward(x_val_right, target_right, XVAL_W'(SLEW_STEP));
`else
    assign run_left  = target_left;
    assign run_right = target_right;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_state   <= OFF;
            x_val_left   <= '0;
            x_val_right  <= '0;
            shadow_left  <= POS_W'(CENTER);
            shadow_right <= POS_W'(CENTER);
            fresh        <= 1'b0;
            miss_cnt     <= '0;
            frame_start  <= 1'b0;
            link_ok      <= 1'b0;
        end else begin
            frame_start <= commit;
            if (accept) begin
                if (sample_ch) shadow_right <= sample_clamped;
                else           shadow_left  <= sample_clamped;
                fresh <= 1'b1;
            end
            if (commit) begin
                fresh <= 1'b0;
                case (ctrl_state)
                    OFF, HOLD: begin
                        // Entry into RUN always jumps straight to the target.
                        if (fresh) begin
                            ctrl_state  <= RUN;
                            link_ok     <= 1'b1;
                            miss_cnt    <= '0;
                            x_val_left  <= target_left;
                            x_val_right <= target_right;
                        end
                    end
                    RUN: begin
                        if (fresh) begin
                            miss_cnt    <= '0;
                            x_val_left  <= run_left;
                            x_val_right <= run_right;
                        end else if (miss_cnt >= MISS_W'(TIMEOUT_FRAMES - 1)) begin
                            ctrl_state  <= HOLD;
                            link_ok     <= 1'b0;
                            miss_cnt    <= MISS_W'(TIMEOUT_FRAMES);
                            x_val_left  <= center_val;
                            x_val_right <= center_val;
                        end else begin
                            miss_cnt    <= miss_cnt + 1'b1;
                            x_val_left  <= run_left;
                            x_val_right <= run_right;
                        end
                    end
                    default: begin
                        ctrl_state <= OFF;
                        link_ok    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
